// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : streams 32-bit words into byte-wide instruction memory, MSB
// first. Optional macro IMEM_LOADER_BOUND_CHECK_EN aborts on address bound.
// Revision 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  input  logic              word_last,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              hold_pipeline,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    WRITE     = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr, addr_next;
  logic [31:0]       word_buf, word_buf_next;
  logic              last_buf, last_buf_next;
  logic [1:0]        beat, beat_next;

`ifdef IMEM_LOADER_BOUND_CHECK_EN
  // Highest base that still fits a whole 4-byte word below the top of memory.
  localparam logic [ADDR_W-1:0] LAST_SAFE = ~ADDR_W'(3);
  logic ovf, ovf_next;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      addr     <= '0;
      word_buf <= '0;
      last_buf <= 1'b0;
      beat     <= 2'd0;
`ifdef IMEM_LOADER_BOUND_CHECK_EN
      ovf      <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      addr     <= addr_next;
      word_buf <= word_buf_next;
      last_buf <= last_buf_next;
      beat     <= beat_next;
`ifdef IMEM_LOADER_BOUND_CHECK_EN
      ovf      <= ovf_next;
`endif
    end
  end

  always_comb begin
    state_next    = state;
    addr_next     = addr;
    word_buf_next = word_buf;
    last_buf_next = last_buf;
    beat_next     = beat;
`ifdef IMEM_LOADER_BOUND_CHECK_EN
    ovf_next      = ovf;
`endif
    word_ready    = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = 8'h00;
    busy          = 1'b1;
    done          = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (load_start) begin
          addr_next  = base_addr;
          state_next = WAIT_WORD;
`ifdef IMEM_LOADER_BOUND_CHECK_EN
          ovf_next   = 1'b0;
`endif
        end
      end
      WAIT_WORD: begin
        word_ready = 1'b1;
        if (word_valid) begin
`ifdef IMEM_LOADER_BOUND_CHECK_EN
          if (addr > LAST_SAFE) begin
            ovf_next   = 1'b1;
            state_next = DONE;
          end else begin
            word_buf_next = word_data;
            last_buf_next = word_last;
            beat_next     = 2'd0;
            state_next    = WRITE;
          end
`else
          word_buf_next = word_data;
          last_buf_next = word_last;
          beat_next     = 2'd0;
          state_next    = WRITE;
`endif
        end
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = addr;
        case (beat)
          2'd0:    mem_wdata = word_buf[31:24];
          2'd1:    mem_wdata = word_buf[23:16];
          2'd2:    mem_wdata = word_buf[15:8];
          default: mem_wdata = word_buf[7:0];
        endcase
        addr_next = addr + 1'b1;
        beat_next = beat + 2'd1;
        if (beat == 2'd3) begin
          state_next = last_buf ? DONE : WAIT_WORD;
        end
      end
      default: begin
        done       = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  assign hold_pipeline = busy;

`ifdef IMEM_LOADER_BOUND_CHECK_EN
  assign overflow = ovf;
`else
  assign overflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader : directed + randomized checks of imem_loader against a
// byte-stream reference model. Revision 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       load_start;
  logic [7:0] base_addr;
  logic       word_valid;
  logic [31:0] word_data;
  logic       word_last;
  logic       word_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       hold_pipeline;
  logic       done;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [15:0] wlog[$];
  logic [7:0]  mem_img[256];
  logic [31:0] words[4];
  int          gaps[4];

  imem_loader #(.ADDR_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .load_start(load_start), .base_addr(base_addr),
    .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
    .word_ready(word_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .hold_pipeline(hold_pipeline),
    .done(done), .overflow(overflow)
  );

  always #5 Clk = ~Clk;

  // Memory-side observer: mid-cycle capture of every byte write and done pulse.
  always @(negedge Clk) begin
    if (mem_we) begin
      wlog.push_back({mem_addr, mem_wdata});
      mem_img[mem_addr] = mem_wdata;
    end
    if (done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {word_ready, mem_we, mem_addr, mem_wdata, busy,
                         hold_pipeline, done, overflow}, 32'h0);
  endtask

  // Drives one session and compares the write stream with the expected
  // sequence of bytes: base+j (mod 256) receives byte (j%4) of word j/4, MSB first.
  task automatic run_session(input logic [7:0] base, input int n, input bit poke);
    int to;
    int d0;
    logic [7:0] ea;
    logic [7:0] ed;
    wlog.delete();
    d0 = done_cnt;
    base_addr  = base;
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat (gaps[i]) tick;
      word_valid = 1'b1;
      word_data  = words[i];
      word_last  = (i == n - 1);
      to = 0;
      while (!word_ready && to < 50) begin
        tick;
        to++;
      end
      chk("ready_seen", {31'd0, word_ready}, 32'd1);
      tick;
      word_valid = 1'b0;
      word_last  = 1'b0;
      if (poke && i == 0) begin
        tick;
        base_addr  = 8'h80;
        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        base_addr  = base;
      end
    end
    to = 0;
    while (done_cnt == d0 && to < 50) begin
      tick;
      to++;
    end
    chk("done_once", done_cnt - d0, 32'd1);
    chk("ovf_clear", {31'd0, overflow}, 32'd0);
    tick;
    chk("idle_after", {30'd0, busy, hold_pipeline}, 32'd0);
    chk("wlog_len", wlog.size(), 4 * n);
    for (int j = 0; j < wlog.size() && j < 4 * n; j++) begin
      ea = 8'((int'(base) + j) % 256);
      ed = 8'(words[j / 4] >> (24 - 8 * (j % 4)));
      chk("wr_byte", {16'd0, wlog[j]}, {16'd0, ea, ed});
    end
  endtask

  initial begin
    Reset = 1'b1; load_start = 1'b0; base_addr = 8'h00;
    word_valid = 1'b0; word_data = 32'h0; word_last = 1'b0;
    for (int i = 0; i < 256; i++) mem_img[i] = 8'h00;
    tick; tick;
    chk_all_zero("reset");
    Reset = 1'b0;
    tick;
    chk_all_zero("idle");

    // Single word, exact cycle timing.
    base_addr = 8'h10; load_start = 1'b1;
    word_valid = 1'b1; word_data = 32'hE3A01005; word_last = 1'b1;
    tick;
    load_start = 1'b0;
    chk("c1_ready_hold", {29'd0, word_ready, hold_pipeline, mem_we}, 32'b110);
    tick;
    word_valid = 1'b0; word_last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("c2_5_we_hold", {30'd0, mem_we, hold_pipeline}, 32'b11);
      chk("c2_5_addr", {24'd0, mem_addr}, 32'(8'h10 + k));
      chk("c2_5_data", {24'd0, mem_wdata}, (32'hE3A01005 >> (24 - 8 * k)) & 32'hFF);
      tick;
    end
    chk("c6_done", {29'd0, done, hold_pipeline, mem_we}, 32'b110);
    tick;
    chk("c7_idle", {29'd0, done, busy, hold_pipeline}, 32'd0);

    // Three words with gaps; fetch of 0x04 returns word 2.
    words[0] = 32'h01020304; words[1] = 32'hA5B6C7D8; words[2] = 32'hDEADBEEF;
    gaps[0] = 0; gaps[1] = 1; gaps[2] = 3;
    run_session(8'h00, 3, 1'b0);
    chk("fetch_04", {mem_img[4], mem_img[5], mem_img[6], mem_img[7]}, 32'hA5B6C7D8);

    // load_start during WRITE must be ignored.
    words[0] = 32'h11111111; words[1] = 32'h22222222;
    gaps[0] = 0; gaps[1] = 0;
    run_session(8'h20, 2, 1'b1);

    // Reset after two write beats.
    wlog.delete();
    base_addr = 8'h40; load_start = 1'b1;
    word_valid = 1'b1; word_data = 32'hCAFEF00D; word_last = 1'b1;
    tick;
    load_start = 1'b0;
    tick;
    tick;
    Reset = 1'b1;
    tick;
    chk_all_zero("mid_reset");
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("post_reset_ready", {30'd0, word_ready, mem_we}, 32'd0);
    end
    word_valid = 1'b0; word_last = 1'b0;
    chk("reset_two_bytes", wlog.size(), 32'd2);

    // Top-of-memory word.
`ifdef IMEM_LOADER_BOUND_CHECK_EN
    wlog.delete();
    base_addr = 8'hFE; load_start = 1'b1;
    word_valid = 1'b1; word_data = 32'h11223344; word_last = 1'b1;
    tick;
    load_start = 1'b0;
    tick;
    word_valid = 1'b0; word_last = 1'b0;
    chk("bound_c2", {29'd0, done, overflow, mem_we}, 32'b110);
    tick;
    tick;
    chk("bound_hold", {30'd0, overflow, busy}, 32'b10);
    chk("bound_nowrite", wlog.size(), 32'd0);
`else
    words[0] = 32'h11223344; gaps[0] = 0;
    run_session(8'hFE, 1, 1'b0);
`endif

    // word_valid in IDLE without load_start.
    wlog.delete();
    word_valid = 1'b1; word_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("idle_valid", {30'd0, busy, word_ready}, 32'd0);
    end
    word_valid = 1'b0; word_last = 1'b0;
    chk("idle_nowrite", wlog.size(), 32'd0);

    // Randomized sessions kept clear of the top of memory.
    for (int s = 0; s < 8; s++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) begin
        words[i] = $urandom;
        gaps[i]  = $urandom_range(0, 3);
      end
      run_session(8'($urandom_range(0, 8'hC0)), n, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
